// File: rtl/mux_scan_seq_if.sv
// Bundle of the load handshake, the MUX-facing bus and the scan results
// exchanged between mux_scan_seq and its surroundings.
interface mux_scan_seq_if;
    // Load handshake
    logic [3:0] Data_In;
    logic       Load_Valid;
    logic       Load_Ready;

    // MUX stage connection
    logic [3:0] Mux_In;
    logic [1:0] Mux_Sel;
    logic       Mux_Out;

    // Serial and reassembled results
    logic       Bit_Out;
    logic       Bit_Valid;
    logic [3:0] Word_Out;
    logic       Word_Valid;
    logic       Mismatch;
    logic       Busy;

    // Environment side: supplies words and the MUX return, observes results
    modport master (
        output Data_In,
        output Load_Valid,
        output Mux_Out,
        input  Load_Ready,
        input  Mux_In,
        input  Mux_Sel,
        input  Bit_Out,
        input  Bit_Valid,
        input  Word_Out,
        input  Word_Valid,
        input  Mismatch,
        input  Busy
    );

    // Sequencer side
    modport slave (
        input  Data_In,
        input  Load_Valid,
        input  Mux_Out,
        output Load_Ready,
        output Mux_In,
        output Mux_Sel,
        output Bit_Out,
        output Bit_Valid,
        output Word_Out,
        output Word_Valid,
        output Mismatch,
        output Busy
    );
endinterface

// File: rtl/mux_scan_seq.sv
// Scan sequencer for a 4:1 single-bit MUX stage. A loaded word is held on
// the MUX data bus while the select steps 0..3; the MUX output is sampled
// once per step (after DWELL cycles of settling), emitted LSB first, then
// reassembled and compared against the launched word.
module mux_scan_seq #(
    parameter int DWELL = 1          // cycles per select value, 1..8
) (
    input  logic          Clk,
    input  logic          Rst_n,
    mux_scan_seq_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STEP = 2'd1,
        DONE = 2'd2
    } state_t;

    // Dwell counter value on the sampling edge of each select step
    localparam logic [2:0] LAST_CNT = 3'(DWELL - 1);

    state_t     state_reg,      state_next;
    logic [3:0] mux_in_reg,     mux_in_next;
    logic [1:0] mux_sel_reg,    mux_sel_next;
    logic [2:0] cnt_reg,        cnt_next;
    logic [3:0] asm_reg,        asm_next;
    logic       bit_out_reg,    bit_out_next;
    logic       bit_valid_reg,  bit_valid_next;
    logic [3:0] word_out_reg,   word_out_next;
    logic       word_valid_reg, word_valid_next;
    logic       mismatch_reg,   mismatch_next;

    // Assembly register with the current MUX return merged at the select slot
    logic [3:0] asm_with_bit;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_asm_bit
            assign asm_with_bit[gi] = (mux_sel_reg == 2'(gi)) ? bus.Mux_Out
                                                              : asm_reg[gi];
        end
    endgenerate

    // State register and all datapath registers, cleared asynchronously
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_reg      <= IDLE;
            mux_in_reg     <= 4'd0;
            mux_sel_reg    <= 2'd0;
            cnt_reg        <= 3'd0;
            asm_reg        <= 4'd0;
            bit_out_reg    <= 1'b0;
            bit_valid_reg  <= 1'b0;
            word_out_reg   <= 4'd0;
            word_valid_reg <= 1'b0;
            mismatch_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            mux_in_reg     <= mux_in_next;
            mux_sel_reg    <= mux_sel_next;
            cnt_reg        <= cnt_next;
            asm_reg        <= asm_next;
            bit_out_reg    <= bit_out_next;
            bit_valid_reg  <= bit_valid_next;
            word_out_reg   <= word_out_next;
            word_valid_reg <= word_valid_next;
            mismatch_reg   <= mismatch_next;
        end
    end

    // Next-state and datapath updates; pulses default low, everything else holds
    always_comb begin
        state_next      = state_reg;
        mux_in_next     = mux_in_reg;
        mux_sel_next    = mux_sel_reg;
        cnt_next        = cnt_reg;
        asm_next        = asm_reg;
        bit_out_next    = bit_out_reg;
        bit_valid_next  = 1'b0;
        word_out_next   = word_out_reg;
        word_valid_next = 1'b0;
        mismatch_next   = mismatch_reg;

        case (state_reg)
            IDLE: begin
                if (bus.Load_Valid) begin
                    mux_in_next  = bus.Data_In;
                    mux_sel_next = 2'd0;
                    cnt_next     = 3'd0;
                    asm_next     = 4'd0;
                    state_next   = STEP;
                end
            end

            STEP: begin
                // Data bus stays frozen; only the select and counter move
                cnt_next = cnt_reg + 3'd1;
                if (cnt_reg == LAST_CNT) begin
                    bit_out_next   = bus.Mux_Out;
                    bit_valid_next = 1'b1;
                    asm_next       = asm_with_bit;
                    cnt_next       = 3'd0;
                    if (mux_sel_reg == 2'd3) begin
                        // Last bit: publish the word; select stays at 3
                        word_out_next   = asm_with_bit;
                        mismatch_next   = (asm_with_bit != mux_in_reg);
                        word_valid_next = 1'b1;
                        state_next      = DONE;
                    end else begin
                        mux_sel_next = mux_sel_reg + 2'd1;
                    end
                end
            end

            DONE: begin
                // One-cycle hold so the result pulses are seen before re-arming
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.Load_Ready = (state_reg == IDLE);
    assign bus.Busy       = (state_reg == STEP) || (state_reg == DONE);
    assign bus.Mux_In     = mux_in_reg;
    assign bus.Mux_Sel    = mux_sel_reg;
    assign bus.Bit_Out    = bit_out_reg;
    assign bus.Bit_Valid  = bit_valid_reg;
    assign bus.Word_Out   = word_out_reg;
    assign bus.Word_Valid = word_valid_reg;
    assign bus.Mismatch   = mismatch_reg;

endmodule

// File: doc/mux_scan_seq.md
# mux_scan_seq

Sequencer that sits directly upstream of the 4:1 single-bit MUX stage. It accepts a 4-bit word over a valid/ready handshake and holds it stable on the MUX data bus. It steps the MUX select through 0..3, samples the MUX output once per step, and emits the bits serially. It then reassembles the word and flags any mismatch against the word it launched, giving a self-checking serial path through the MUX.

## Interface
- DWELL, 1, clock cycles each select value is held before sampling; legal 1..8
- Clk  in  1  rising-edge clock
- Rst_n  in  1  reset, asynchronous, active-low
- Data_In  in  4  word to scan
- Load_Valid  in  1  Data_In is valid this cycle
- Load_Ready  out  1  block can accept a word; high only in IDLE
- Mux_In  out  4  data bus driven into the MUX In port
- Mux_Sel  out  2  select driven into the MUX Sel port
- Mux_Out  in  1  MUX Out, combinational return from the MUX stage
- Bit_Out  out  1  sampled serial bit
- Bit_Valid  out  1  one-cycle pulse qualifying Bit_Out
- Word_Out  out  4  reassembled word
- Word_Valid  out  1  one-cycle pulse qualifying Word_Out and Mismatch
- Mismatch  out  1  Word_Out differs from launched word
- Busy  out  1  high in STEP and DONE

## Operation
- States: IDLE, STEP, DONE. Reset state is IDLE.
- **IDLE**
  - Load_Ready=1, Busy=0.
  - On a clock edge with Load_Valid=1: Mux_In<=Data_In, Mux_Sel<=0, dwell counter<=0, assembly register<=0, go to STEP.
- **STEP**
  - Mux_In is frozen for the whole scan.
  - Dwell counter increments every cycle.
  - On the edge where counter==DWELL-1:
    - Bit_Out<=Mux_Out and Bit_Valid<=1.
    - Assembly bit [Mux_Sel]<=Mux_Out.
    - Counter<=0.
    - If Mux_Sel==3: Word_Out<=assembled word including this bit, Mismatch<=(that word != Mux_In), Word_Valid<=1, go to DONE.
    - Otherwise Mux_Sel<=Mux_Sel+1.
  - Bit_Valid is 0 on every other edge.
- **DONE**
  - Busy=1, Load_Ready=0.
  - Lasts exactly one cycle; next edge clears Word_Valid and Bit_Valid and goes to IDLE.
  - Mux_Sel stays at 3; Mux_In keeps the last word.
- Bit order: LSB first, so bit i is sampled at Mux_Sel=i.
- Word_Out and Mismatch hold their values until the next word completes.
- Load_Valid while Busy is ignored, and Data_In is not sampled. The upstream source must hold Load_Valid until it sees Load_Ready.
- Mux_Sel never wraps inside a scan. The 3 to 0 transition happens only on a new load.
- Reset values (asserted asynchronously, mid-scan included):
  - state=IDLE, Mux_In=0, Mux_Sel=0, dwell counter=0, assembly=0
  - Bit_Out=0, Bit_Valid=0, Word_Out=0, Word_Valid=0, Mismatch=0
  - Load_Ready=1, Busy=0
- An aborted scan produces no Word_Valid, and partial bits are discarded.

## Timing
- All outputs are registered except Load_Ready and Busy, which decode the state register.
- Load accept at edge E0. Bit i is sampled at edge E0+(i+1)*DWELL. Bit_Valid is high for the cycle following each of those edges.
- Word_Valid is high for the cycle after edge E0+4*DWELL, coincident with the fourth Bit_Valid.
- Load_Ready returns high after edge E0+4*DWELL+1. The earliest next accept is edge E0+4*DWELL+2.
- Throughput is one word per 4*DWELL+2 cycles.
- Mux_Out is sampled at the end of the last dwell cycle, so the MUX path has DWELL cycles to settle. With DWELL=1 that is one full clock period.

## Test plan
- **Reset:** hold Rst_n=0 with Load_Valid=1 and Data_In=4'hF. All outputs read at their reset values, Load_Ready=1. Release Rst_n; the load is accepted on the first edge.
- **Basic scan, DWELL=1:** real MUX attached, load 4'b1010. Mux_Sel reads 0,1,2,3 on consecutive cycles. Bit_Out=0,1,0,1 with Bit_Valid high 4 cycles. Word_Valid pulses 4 cycles after accept with Word_Out=4'b1010 and Mismatch=0.
- **Back-to-back:** Load_Valid held high, Data_In=4'hF and then changed to 4'h3 one cycle after accept.
  - First scan returns 4'hF; the mid-scan change is ignored.
  - 4'h3 is accepted exactly 6 cycles after the first accept.
  - Second Word_Out=4'h3.
- **Fault injection:** Mux_Out forced to 0, load 4'b0110 → Word_Out=4'b0000, Mismatch=1. Release the force and load 4'h0 → Word_Out=4'h0, Mismatch=0.
- **DWELL=3:** load 4'h9. Each Mux_Sel value holds 3 cycles. Bit_Valid pulses are 3 cycles apart. Word_Valid comes 12 cycles after accept with Word_Out=4'h9.
- **Mid-scan reset:** assert Rst_n=0 while Mux_Sel==2. All outputs go to reset values immediately, with no Word_Valid. After release, Load_Ready=1 and a new load of 4'h5 completes with Word_Out=4'h5.
